// File: rtl/cardinal_branch_unit_pkg.sv
// Shared types and constants for the gshare branch unit and its checkpoint FIFO.
package cardinal_branch_unit_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  localparam logic [3:0] BRANCH_EZ = 4'hA;
  localparam logic [3:0] BRANCH_NZ = 4'hB;

  // Checkpoint layout: index, predicted direction, fall-through PC, target PC, GHR snapshot.
  function automatic int unsigned ckpt_width(input int unsigned addr_w,
                                             input int unsigned idx_w,
                                             input int unsigned hist_w);
    return idx_w + 1 + 2 * addr_w + hist_w;
  endfunction

endpackage

// File: rtl/cardinal_ckpt_fifo.sv
// In-order checkpoint FIFO with push, pop and a clear that overrides push.
module cardinal_ckpt_fifo
  import cardinal_branch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full      = (count == CNT_W'(DEPTH));
    empty     = (count == '0);
    do_push   = push & ~full;
    do_pop    = pop & ~empty;
    head_data = mem[rd_ptr];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cardinal_branch_unit.sv
// Gshare predictor with a FIFO of in-flight branch checkpoints; resolves the oldest
// branch, trains its counter and flushes/redirects on misprediction.
module cardinal_branch_unit
  import cardinal_branch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned HIST_W     = 4,
  parameter int unsigned PEND_DEPTH = 2,
  parameter logic [1:0]  CTR_INIT   = 2'b01
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              fetch_valid,
  input  logic              fetch_is_branch,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic [ADDR_W-1:0] fetch_target,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  output logic              pend_full,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              resolve_err
);

  localparam int unsigned CTR_N  = 2 ** IDX_W;
  localparam int unsigned CKPT_W = ckpt_width(ADDR_W, IDX_W, HIST_W);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              pred;
    logic [ADDR_W-1:0] fallthrough;
    logic [ADDR_W-1:0] target;
    logic [HIST_W-1:0] ghr;
  } ckpt_t;

  ctr_e              ctr [CTR_N];
  logic [HIST_W-1:0] ghr;
  logic [IDX_W-1:0]  fetch_idx;
  logic [ADDR_W-1:0] fallthrough_pc;
  ckpt_t             push_entry;
  ckpt_t             head;
  logic [CKPT_W-1:0] head_data;
  logic              fifo_empty;
  logic              resolve_hit;
  logic              mispredict;
  logic              do_push;

  always_comb begin
    fetch_idx      = fetch_pc[IDX_W-1:0] ^ IDX_W'(ghr);
    fallthrough_pc = fetch_pc + 1'b1;
    pred_taken     = fetch_is_branch & (ctr[fetch_idx] inside {WT, ST});
    pred_next_pc   = pred_taken ? fetch_target : fallthrough_pc;

    head        = ckpt_t'(head_data);
    resolve_hit = resolve_valid & ~fifo_empty;
    mispredict  = resolve_hit & (resolve_taken != head.pred);
    flush       = mispredict;
    redirect_pc = '0;
    if (mispredict) redirect_pc = resolve_taken ? head.target : head.fallthrough;

    do_push                = fetch_valid & fetch_is_branch & ~pend_full & ~mispredict;
    push_entry.idx         = fetch_idx;
    push_entry.pred        = pred_taken;
    push_entry.fallthrough = fallthrough_pc;
    push_entry.target      = fetch_target;
    push_entry.ghr         = ghr;
  end

  cardinal_ckpt_fifo #(
    .WIDTH (CKPT_W),
    .DEPTH (PEND_DEPTH)
  ) u_ckpt_fifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (do_push),
    .push_data (push_entry),
    .pop       (resolve_hit),
    .clear     (mispredict),
    .head_data (head_data),
    .full      (pend_full),
    .empty     (fifo_empty)
  );

  // History shifts via truncation of {ghr, bit} so HIST_W == 1 needs no special slice.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < CTR_N; i++) ctr[i] <= ctr_e'(CTR_INIT);
      ghr         <= '0;
      resolve_err <= 1'b0;
    end else begin
      if (resolve_hit) begin
        if (resolve_taken) begin
          if (ctr[head.idx] != ST) ctr[head.idx] <= ctr_e'(ctr[head.idx] + 2'd1);
        end else begin
          if (ctr[head.idx] != SNT) ctr[head.idx] <= ctr_e'(ctr[head.idx] - 2'd1);
        end
      end
      if (mispredict)   ghr <= HIST_W'({head.ghr, resolve_taken});
      else if (do_push) ghr <= HIST_W'({ghr, pred_taken});
      if (resolve_valid && fifo_empty) resolve_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cardinal_branch_unit.sv
// Self-checking bench for cardinal_branch_unit: directed scenarios plus randomized
// traffic against a queue-based behavioural model.
module tb_cardinal_branch_unit;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       fetch_valid, fetch_is_branch, resolve_valid, resolve_taken;
  logic [7:0] fetch_pc, fetch_target;
  logic       pred_taken, pend_full, flush, resolve_err;
  logic [7:0] pred_next_pc, redirect_pc;

  int checks = 0;
  int errors = 0;

  cardinal_branch_unit #(
    .ADDR_W     (8),
    .IDX_W      (4),
    .HIST_W     (4),
    .PEND_DEPTH (2),
    .CTR_INIT   (2'b01)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .fetch_valid     (fetch_valid),
    .fetch_is_branch (fetch_is_branch),
    .fetch_pc        (fetch_pc),
    .fetch_target    (fetch_target),
    .pred_taken      (pred_taken),
    .pred_next_pc    (pred_next_pc),
    .pend_full       (pend_full),
    .resolve_valid   (resolve_valid),
    .resolve_taken   (resolve_taken),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .resolve_err     (resolve_err)
  );

  always #5 Clock = ~Clock;

  // Behavioural model: counters as integers 0..3, history as an int, checkpoints in a queue.
  typedef struct {
    int idx;
    bit pred;
    int ft;
    int tgt;
    int ghr;
  } ent_t;

  int   m_ctr [16];
  int   m_ghr;
  ent_t m_q[$];
  bit   m_err;

  function automatic void model_reset();
    foreach (m_ctr[i]) m_ctr[i] = 1;
    m_ghr = 0;
    m_q.delete();
    m_err = 0;
  endfunction

  function automatic void exp_out(output bit pt, output int npc, output bit fl,
                                  output int rpc, output bit full);
    int idx;
    idx  = (int'(fetch_pc) % 16) ^ m_ghr;
    pt   = fetch_is_branch && (m_ctr[idx] >= 2);
    npc  = pt ? int'(fetch_target) : (int'(fetch_pc) + 1) % 256;
    fl   = resolve_valid && (m_q.size() > 0) && (resolve_taken != m_q[0].pred);
    rpc  = fl ? (resolve_taken ? m_q[0].tgt : m_q[0].ft) : 0;
    full = (m_q.size() == 2);
  endfunction

  function automatic void model_step();
    bit   pt, fl, full, push;
    int   npc, rpc, idx;
    ent_t h, e;
    exp_out(pt, npc, fl, rpc, full);
    idx  = (int'(fetch_pc) % 16) ^ m_ghr;
    push = fetch_valid && fetch_is_branch && !full && !fl;
    if (resolve_valid && m_q.size() == 0) m_err = 1;
    if (resolve_valid && m_q.size() > 0) begin
      h = m_q.pop_front();
      if (resolve_taken) m_ctr[h.idx] = (m_ctr[h.idx] == 3) ? 3 : m_ctr[h.idx] + 1;
      else               m_ctr[h.idx] = (m_ctr[h.idx] == 0) ? 0 : m_ctr[h.idx] - 1;
    end
    if (fl) begin
      m_q.delete();
      m_ghr = (h.ghr * 2 + int'(resolve_taken)) % 16;
    end else if (push) begin
      e.idx = idx; e.pred = pt; e.ft = (int'(fetch_pc) + 1) % 256;
      e.tgt = int'(fetch_target); e.ghr = m_ghr;
      m_q.push_back(e);
      m_ghr = (m_ghr * 2 + int'(pt)) % 16;
    end
  endfunction

  task automatic tick();
    @(posedge Clock);
    model_step();
    #1;
  endtask

  task automatic drive(input bit fv, input bit fb, input int pc, input int tgt,
                       input bit rv, input bit rt);
    fetch_valid = fv; fetch_is_branch = fb; fetch_pc = 8'(pc); fetch_target = 8'(tgt);
    resolve_valid = rv; resolve_taken = rt;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    model_reset();
    drive(0, 1, 'h00, 'h00, 0, 0);
    repeat (2) @(posedge Clock);
    #2;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %0h want 0", pred_taken); end
    checks++; if (pred_next_pc !== 8'h01) begin errors++; $display("FAIL reset_npc: got %0h want 01", pred_next_pc); end
    checks++; if (pend_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0h want 0", pend_full); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0h want 0", flush); end
    checks++; if (redirect_pc !== 8'h00) begin errors++; $display("FAIL reset_rpc: got %0h want 00", redirect_pc); end
    checks++; if (resolve_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0h want 0", resolve_err); end
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_predict_resolve();
    drive(1, 1, 'h10, 'h40, 0, 0);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL first_pred: got %0h want 0", pred_taken); end
    checks++; if (pred_next_pc !== 8'h11) begin errors++; $display("FAIL first_npc: got %0h want 11", pred_next_pc); end
    tick();
    drive(0, 0, 0, 0, 1, 1);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mis_flush: got %0h want 1", flush); end
    checks++; if (redirect_pc !== 8'h40) begin errors++; $display("FAIL mis_rpc: got %0h want 40", redirect_pc); end
    tick();
    drive(1, 1, 'h11, 'h50, 0, 0);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL trained_pred: got %0h want 1", pred_taken); end
    checks++; if (pred_next_pc !== 8'h50) begin errors++; $display("FAIL trained_npc: got %0h want 50", pred_next_pc); end
    checks++; if (pend_full !== 1'b0) begin errors++; $display("FAIL empty_after_flush: got %0h want 0", pend_full); end
    tick();
    drive(0, 0, 0, 0, 1, 1);
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL correct_flush: got %0h want 0", flush); end
    checks++; if (redirect_pc !== 8'h00) begin errors++; $display("FAIL correct_rpc: got %0h want 00", redirect_pc); end
    tick();
    drive(1, 1, 'h13, 'h60, 0, 0);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL strong_pred: got %0h want 1", pred_taken); end
    tick();
    drive(0, 0, 0, 0, 1, 1);
    tick();
    drive(1, 1, 'h17, 'h70, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL nt_flush: got %0h want 1", flush); end
    checks++; if (redirect_pc !== 8'h18) begin errors++; $display("FAIL nt_rpc: got %0h want 18", redirect_pc); end
    tick();
    drive(1, 1, 'h1E, 'h20, 0, 0);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL after_one_nt: got %0h want 1", pred_taken); end
    tick();
    drive(0, 0, 0, 0, 1, 0);
    checks++; if (redirect_pc !== 8'h1F) begin errors++; $display("FAIL nt2_rpc: got %0h want 1f", redirect_pc); end
    tick();
    // Counter saturated at 3 then took two decrements: must now read weakly not-taken.
    drive(0, 1, 'h1C, 'h99, 0, 0);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL saturation: got %0h want 0", pred_taken); end
    checks++; if (pred_next_pc !== 8'h1D) begin errors++; $display("FAIL sat_npc: got %0h want 1d", pred_next_pc); end
  endtask

  task automatic test_full();
    drive(1, 1, 'h30, 'h80, 0, 0);
    tick();
    drive(1, 1, 'h31, 'h90, 0, 0);
    checks++; if (pend_full !== 1'b0) begin errors++; $display("FAIL one_entry_full: got %0h want 0", pend_full); end
    tick();
    drive(1, 1, 'h32, 'hA0, 0, 0);
    checks++; if (pend_full !== 1'b1) begin errors++; $display("FAIL two_entry_full: got %0h want 1", pend_full); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (pend_full !== 1'b1) begin errors++; $display("FAIL third_push_ignored: got %0h want 1", pend_full); end
    drive(0, 0, 0, 0, 1, 1);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL oldest_flush: got %0h want 1", flush); end
    checks++; if (redirect_pc !== 8'h80) begin errors++; $display("FAIL oldest_rpc: got %0h want 80", redirect_pc); end
    tick();
    drive(0, 1, 'h35, 'hC0, 0, 0);
    checks++; if (pend_full !== 1'b0) begin errors++; $display("FAIL cleared_full: got %0h want 0", pend_full); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL restored_ghr_pred: got %0h want 1", pred_taken); end
    checks++; if (pred_next_pc !== 8'hC0) begin errors++; $display("FAIL restored_ghr_npc: got %0h want c0", pred_next_pc); end
  endtask

  task automatic test_resolve_err();
    drive(0, 0, 0, 0, 1, 1);
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL empty_resolve_flush: got %0h want 0", flush); end
    checks++; if (resolve_err !== 1'b0) begin errors++; $display("FAIL err_before_edge: got %0h want 0", resolve_err); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (resolve_err !== 1'b1) begin errors++; $display("FAIL err_set: got %0h want 1", resolve_err); end
    tick();
    tick();
    checks++; if (resolve_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0h want 1", resolve_err); end
  endtask

  task automatic test_wrap();
    drive(0, 1, 'hFF, 'h44, 0, 0);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL wrap_pred: got %0h want 0", pred_taken); end
    checks++; if (pred_next_pc !== 8'h00) begin errors++; $display("FAIL wrap_npc: got %0h want 00", pred_next_pc); end
    drive(0, 0, 'hFF, 'h44, 0, 0);
    checks++; if (pred_next_pc !== 8'h00) begin errors++; $display("FAIL wrap_nonbranch: got %0h want 00", pred_next_pc); end
  endtask

  task automatic test_random();
    bit pt, fl, full;
    int npc, rpc;
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      exp_out(pt, npc, fl, rpc, full);
      checks++; if (pred_taken !== pt) begin errors++; $display("FAIL rnd_pred[%0d]: got %0h want %0h", i, pred_taken, pt); end
      checks++; if (pred_next_pc !== 8'(npc)) begin errors++; $display("FAIL rnd_npc[%0d]: got %0h want %0h", i, pred_next_pc, npc); end
      checks++; if (flush !== fl) begin errors++; $display("FAIL rnd_flush[%0d]: got %0h want %0h", i, flush, fl); end
      checks++; if (redirect_pc !== 8'(rpc)) begin errors++; $display("FAIL rnd_rpc[%0d]: got %0h want %0h", i, redirect_pc, rpc); end
      checks++; if (pend_full !== full) begin errors++; $display("FAIL rnd_full[%0d]: got %0h want %0h", i, pend_full, full); end
      checks++; if (resolve_err !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %0h want %0h", i, resolve_err, m_err); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    Reset = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    #1;
    tick();
    drive(1, 1, 'h10, 'h40, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 1);
    tick();
    drive(1, 1, 'h11, 'h50, 0, 0);
    tick();
    drive(1, 1, 'h12, 'h60, 0, 0);
    tick();
    drive(0, 1, 'h16, 'h70, 0, 0);
    checks++; if (pend_full !== 1'b1) begin errors++; $display("FAIL pre_reset_full: got %0h want 1", pend_full); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL pre_reset_pred: got %0h want 1", pred_taken); end
    fetch_pc = 8'h10;
    Reset = 1'b1;
    #1;
    checks++; if (pend_full !== 1'b0) begin errors++; $display("FAIL async_full: got %0h want 0", pend_full); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL async_ctr: got %0h want 0", pred_taken); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL async_flush: got %0h want 0", flush); end
    Reset = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    fetch_valid = 1'b0; fetch_is_branch = 1'b0; fetch_pc = '0; fetch_target = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0;
    test_reset();
    test_predict_resolve();
    test_full();
    test_resolve_err();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cardinal_branch_unit.md
Name: cardinal_branch_unit

Overview:
Parametrised successor to the fetch-stage branch predictor and single PC checkpoint. It provides a gshare predictor: a table of 2-bit saturating counters indexed by PC XOR global history. A FIFO holds in-flight branch checkpoints, so several unresolved branches can be outstanding. It sits between IF (predict/push) and ID (resolve/flush), and replaces both the single-checkpoint register and the combinational Next_Addr mux.

Parameters:
ADDR_W, 8, PC / instruction-address width
IDX_W, 4, counter-table index width; 2**IDX_W entries
HIST_W, 4, global history register width; must be <= IDX_W
PEND_DEPTH, 2, max unresolved branches in flight; power of two, >= 1
CTR_INIT, 2'b01, counter reset value (weakly not-taken)

Ports:
Clock  in  1  single clock, rising edge
Reset  in  1  asynchronous, active-high
fetch_valid  in  1  IF stage is presenting an instruction this cycle
fetch_is_branch  in  1  that instruction is BEZ/BNEZ
fetch_pc  in  ADDR_W  address of the fetched instruction
fetch_target  in  ADDR_W  branch target from the immediate field
pred_taken  out  1  prediction for the current fetch (combinational)
pred_next_pc  out  ADDR_W  fetch_target if pred_taken, else fetch_pc+1
pend_full  out  1  checkpoint FIFO full; IF must stall branch fetch
resolve_valid  in  1  ID resolves the oldest pending branch this cycle
resolve_taken  in  1  actual outcome
flush  out  1  misprediction; squash IF_ID (combinational)
redirect_pc  out  ADDR_W  correct next PC when flush=1, else 0
resolve_err  out  1  sticky: resolve arrived with the FIFO empty

Behaviour:
- Async reset:
  - all counters = CTR_INIT; GHR = 0; FIFO empty (count=0, ptrs=0); resolve_err = 0.
  - Combinational outputs then follow from this state: pred_taken reflects CTR_INIT; flush = 0; redirect_pc = 0; pend_full = 0.
- Index = fetch_pc[IDX_W-1:0] XOR {zero-extend GHR to IDX_W}.
- pred_taken = counter[index][1] when fetch_is_branch, else 0.
- Address arithmetic is modulo 2**ADDR_W: fetch_pc+1 wraps 2**ADDR_W-1 to 0.
- Push (edge) when fetch_valid & fetch_is_branch & !pend_full & !flush. The entry stores:
  - index
  - pred_taken
  - fall-through PC (fetch_pc+1)
  - fetch_target
  - GHR snapshot taken before the push
- On push, speculative GHR <= {GHR[HIST_W-2:0], pred_taken}.
- pend_full = (count == PEND_DEPTH). No bypass for a same-cycle pop.
- Resolve acts on the FIFO head, when resolve_valid & count>0:
  - Counter[head.index] saturating update: +1 if taken (max 3), -1 if not (min 0).
  - Pop the head.
  - Mispredict when resolve_taken != head.pred:
    - flush = 1 in the same cycle.
    - redirect_pc = head.target if resolve_taken, else head.fallthrough.
  - On mispredict (edge):
    - FIFO cleared to empty; younger entries are wrong-path.
    - GHR <= {head.ghr[HIST_W-2:0], resolve_taken}.
    - Any same-cycle push is discarded.
  - Correct prediction: GHR unchanged (already speculated). flush = 0.
- resolve_valid with count==0: no state change except resolve_err <= 1. resolve_err clears only on Reset.
- Same-cycle push and correct resolve are both applied; count is unchanged.
- Same-index read and update: the prediction uses the pre-update counter value. The update lands at the edge.
- Reset asserted mid-operation clears everything immediately. No flush is generated for lost entries.
- PEND_DEPTH=1 degenerates to the legacy single-checkpoint behaviour.

Decomposition:
- Shared package:
  - counter encodings (SNT=0, WNT=1, WT=2, ST=3)
  - BRANCH_EZ/BRANCH_NZ opcode constants
  - checkpoint-entry field widths as functions of ADDR_W/IDX_W/HIST_W
- Sub-module: cardinal_ckpt_fifo. Parametrised in-order FIFO with push, pop and clear; clear has priority over push.

Test Plan:
- Reset with CTR_INIT=01; fetch branch at pc=0x10, target=0x40 -> pred_taken=0, pred_next_pc=0x11; one entry pushed.
- Resolve that branch taken -> flush=1 and redirect_pc=0x40 in the same cycle; counter[0x0] becomes 2; GHR=0001; FIFO empty.
- Repeat branch at pc=0x11 (index 0x1^0x1=0): it hits counter 2 -> pred_taken=1, pred_next_pc=target; resolve taken -> flush=0, counter=3, no change on a further taken resolve.
- Push two branches (PEND_DEPTH=2) -> pend_full=1, third push ignored; resolve the oldest mispredicted -> FIFO empty, GHR restored from the oldest snapshot plus outcome.
- fetch_pc=0xFF not-taken prediction -> pred_next_pc=0x00 (wrap).
- resolve_valid with empty FIFO -> resolve_err=1 and stays 1; assert Reset asynchronously mid-cycle with 2 entries pending -> pend_full=0 and counters=CTR_INIT before the next edge.
